// File: rtl/aes128_job_arbiter.sv
// aes128_job_arbiter: round-robin sequencer sharing one aes128 core between
// two job requesters. It runs the core's reset_key/load_data protocol, guards
// each wait with a watchdog, and returns the tagged result on a valid/ready
// channel.
// Build option: define AES_KEY_CACHE_EN so that a job whose key matches the
// last successfully scheduled key skips the key expansion.
module aes128_job_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TCNT_W         = 8
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         req0_valid_i,
    output logic         req0_ready_o,
    input  logic [127:0] req0_key_i,
    input  logic [127:0] req0_data_i,
    input  logic         req0_enc_i,
    input  logic         req1_valid_i,
    output logic         req1_ready_o,
    input  logic [127:0] req1_key_i,
    input  logic [127:0] req1_data_i,
    input  logic         req1_enc_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic         rsp_id_o,
    output logic [127:0] rsp_data_o,
    output logic         rsp_err_o,
    output logic         core_reset_key_o,
    output logic         core_load_data_o,
    output logic         core_enc_or_dec_o,
    output logic [127:0] core_key_o,
    output logic [127:0] core_data_o,
    input  logic         core_key_ready_i,
    input  logic         core_cipher_ready_i,
    input  logic [127:0] core_cipher_text_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY_START,
        S_KEY_WAIT,
        S_LOAD,
        S_RUN,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic                armed_q;
    logic                last_grant_q;
    logic [127:0]        job_key_q, job_data_q;
    logic                job_enc_q, job_id_q;
    logic [TCNT_W-1:0]   wdog_q;
    logic                rsp_valid_q, rsp_id_q, rsp_err_q;
    logic [127:0]        rsp_data_q;

    logic                grant_any, grant_id;
    logic [127:0]        sel_key, sel_data;
    logic                sel_enc;
    logic                cache_hit;
    logic                wait_first, wdog_expired;
    logic                key_done, run_done, abort;
    logic                rsp_fire;

    assign wait_first   = (wdog_q == '0);
    assign wdog_expired = (wdog_q == TCNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_fire     = rsp_valid_q & rsp_ready_i;

    // Arbitration: only in IDLE with no response outstanding; ties go to the
    // requester that did not win last time.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (state_q == S_IDLE && armed_q && !rsp_valid_q) begin
            if (req0_valid_i && req1_valid_i) begin
                grant_any = 1'b1;
                grant_id  = ~last_grant_q;
            end else if (req0_valid_i) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid_i) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    // Payload mux of the requester being granted.
    always_comb begin
        sel_key  = req0_key_i;
        sel_data = req0_data_i;
        sel_enc  = req0_enc_i;
        if (grant_id) begin
            sel_key  = req1_key_i;
            sel_data = req1_data_i;
            sel_enc  = req1_enc_i;
        end
    end

`ifdef AES_KEY_CACHE_EN
    logic         cache_valid_q;
    logic [127:0] cache_key_q;

    assign cache_hit = cache_valid_q && (sel_key == cache_key_q);

    // Remember the last key the core finished expanding; forget it on any
    // abort since the core state is then unknown.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cache_valid_q <= 1'b0;
            cache_key_q   <= '0;
        end else if (abort) begin
            cache_valid_q <= 1'b0;
        end else if (key_done) begin
            cache_valid_q <= 1'b1;
            cache_key_q   <= job_key_q;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // Completion and abort conditions; the first cycle of each wait ignores
    // the ready input because it may still be the previous job's value.
    always_comb begin
        key_done = 1'b0;
        run_done = 1'b0;
        abort    = 1'b0;
        if (state_q == S_KEY_WAIT) begin
            if (!wait_first && core_key_ready_i) key_done = 1'b1;
            else if (wdog_expired)               abort    = 1'b1;
        end else if (state_q == S_RUN) begin
            if (!wait_first && core_cipher_ready_i) run_done = 1'b1;
            else if (wdog_expired)                  abort    = 1'b1;
        end
    end

    // Next-state decode and single-cycle strobes.
    always_comb begin
        state_d          = state_q;
        req0_ready_o     = 1'b0;
        req1_ready_o     = 1'b0;
        core_reset_key_o = 1'b0;
        core_load_data_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    req0_ready_o = ~grant_id;
                    req1_ready_o = grant_id;
                    state_d      = cache_hit ? S_LOAD : S_KEY_START;
                end
            end
            S_KEY_START: begin
                core_reset_key_o = 1'b1;
                state_d          = S_KEY_WAIT;
            end
            S_KEY_WAIT: begin
                if (key_done)   state_d = S_LOAD;
                else if (abort) state_d = S_RESP;
            end
            S_LOAD: begin
                core_load_data_o = 1'b1;
                state_d          = S_RUN;
            end
            S_RUN: begin
                if (run_done || abort) state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_fire) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register, grant history and job payload latched at grant.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= S_IDLE;
            armed_q      <= 1'b0;
            last_grant_q <= 1'b1;
            job_key_q    <= '0;
            job_data_q   <= '0;
            job_enc_q    <= 1'b0;
            job_id_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            if (grant_any) begin
                last_grant_q <= grant_id;
                job_key_q    <= sel_key;
                job_data_q   <= sel_data;
                job_enc_q    <= sel_enc;
                job_id_q     <= grant_id;
            end
        end
    end

    // Watchdog: cleared by the strobe states, counts through each wait.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wdog_q <= '0;
        end else if (state_q == S_KEY_WAIT || state_q == S_RUN) begin
            wdog_q <= wdog_q + TCNT_W'(1);
        end else begin
            wdog_q <= '0;
        end
    end

    // Response register: loaded on completion or abort, held until taken.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else if (abort) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= job_id_q;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
        end else if (run_done) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= job_id_q;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= core_cipher_text_i;
        end else if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid_o       = rsp_valid_q;
    assign rsp_id_o          = rsp_id_q;
    assign rsp_err_o         = rsp_err_q;
    assign rsp_data_o        = rsp_data_q;
    assign core_key_o        = job_key_q;
    assign core_data_o       = job_data_q;
    assign core_enc_or_dec_o = job_enc_q;

endmodule
